// File: rtl/instruction_fetch_unit.sv
// Purpose : single-outstanding instruction fetcher; reads words from instruction memory at pc,
//           issues them to an instruction register, handles branch redirects and squashes.
// Latency : ir_w pulses 1 cycle after the accepting mem_ack when stall=0; back-pressure via stall holds ISSUE.
//
// Ports:
//   clk, rst_n               clock and asynchronous active-low reset
//   run, stall               fetch enable; downstream back-pressure (level)
//   branch_valid/_target     one-cycle redirect request and its 10-bit target
//   mem_req/mem_addr         memory read request and address (held stable while a request is open)
//   mem_ack/mem_rdata        one-cycle read completion and 20-bit instruction word
//   ir_d/ir_w                instruction register data and write enable
//   pc, busy, issue_count    current fetch address, non-idle flag, saturating issue counter

module instruction_fetch_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic [9:0]  branch_target,
    output logic        mem_req,
    output logic [9:0]  mem_addr,
    input  logic        mem_ack,
    input  logic [19:0] mem_rdata,
    output logic [19:0] ir_d,
    output logic        ir_w,
    output logic [9:0]  pc,
    output logic        busy,
    output logic [15:0] issue_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_GAP   = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  pc_q, pc_d;
    logic [9:0]  mem_addr_q, mem_addr_d;
    logic        mem_req_q, mem_req_d;
    logic [19:0] ir_word_q, ir_word_d;
    logic        ir_w_q, ir_w_d;
    logic [15:0] issue_count_q, issue_count_d;
    logic        squash_q, squash_d;
    logic        busy_q, busy_d;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_word_d     = ir_word_q;
        ir_w_d        = 1'b0;
        issue_count_d = issue_count_q;
        squash_d      = squash_q;

        case (state_q)
            S_IDLE: begin
                // A redirect while idle only moves pc; fetching starts on a later cycle.
                if (branch_valid) begin
                    pc_d = branch_target;
                end else if (run) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                if (mem_ack) begin
                    if (squash_q || branch_valid) begin
                        // The returning word belongs to the old path: drop it. pc already
                        // holds the target unless the redirect arrives together with the ack.
                        if (branch_valid) begin
                            pc_d = branch_target;
                        end
                        squash_d = 1'b0;
                        state_d  = S_GAP;
                    end else begin
                        ir_word_d = mem_rdata;
                        pc_d      = pc_q + 10'd1;   // natural 10-bit wrap 1023 -> 0
                        state_d   = S_ISSUE;
                    end
                end else if (branch_valid) begin
                    // Request is still open; memory keeps seeing the old address until it acks.
                    pc_d     = branch_target;
                    squash_d = 1'b1;
                end
            end

            S_GAP: begin
                if (branch_valid) begin
                    pc_d = branch_target;
                end
                state_d = run ? S_FETCH : S_IDLE;
            end

            S_ISSUE: begin
                if (branch_valid) begin
                    pc_d    = branch_target;
                    state_d = S_GAP;
                end else if (!stall) begin
                    ir_w_d = 1'b1;
                    if (issue_count_q != 16'hFFFF) begin
                        issue_count_d = issue_count_q + 16'd1;
                    end
                    state_d = run ? S_FETCH : S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every path out of FETCH passes through ISSUE or GAP, so mem_req always drops for
        // at least one cycle after an ack.
        mem_req_d  = (state_d == S_FETCH);
        // Address is frozen for the whole life of a request; otherwise it tracks pc.
        mem_addr_d = (state_q == S_FETCH) ? mem_addr_q : pc_d;
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= 10'd0;
            mem_addr_q    <= 10'd0;
            mem_req_q     <= 1'b0;
            ir_word_q     <= 20'd0;
            ir_w_q        <= 1'b0;
            issue_count_q <= 16'd0;
            squash_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            mem_addr_q    <= mem_addr_d;
            mem_req_q     <= mem_req_d;
            ir_word_q     <= ir_word_d;
            ir_w_q        <= ir_w_d;
            issue_count_q <= issue_count_d;
            squash_q      <= squash_d;
            busy_q        <= busy_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign ir_d        = ir_word_q;
    assign ir_w        = ir_w_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign issue_count = issue_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        stall;
    logic        branch_valid;
    logic [9:0]  branch_target;
    logic        mem_req;
    logic [9:0]  mem_addr;
    logic        mem_ack;
    logic [19:0] mem_rdata;
    logic [19:0] ir_d;
    logic        ir_w;
    logic [9:0]  pc;
    logic        busy;
    logic [15:0] issue_count;

    int n_asserts = 0;
    int n_fail    = 0;

    instruction_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .stall         (stall),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .ir_d          (ir_d),
        .ir_w          (ir_w),
        .pc            (pc),
        .busy          (busy),
        .issue_count   (issue_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while a request is open; completes it and lets it issue.
    task automatic fetch_issue(input logic [19:0] word);
        mem_ack   = 1'b1;
        mem_rdata = word;
        tick();
        mem_ack   = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; stall = 1'b0; branch_valid = 1'b0;
        branch_target = 10'd0; mem_ack = 1'b0; mem_rdata = 20'd0;
        #12;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_ir_w", ir_w, 0);
        chk("rst_ir_d", ir_d, 0);
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", issue_count, 0);
        tick();
        rst_n = 1'b1;

        // Basic fetch: ack two cycles after request, word 0x0002D at address 0.
        run = 1'b1;
        tick();
        chk("f1_req", mem_req, 1);
        chk("f1_addr", mem_addr, 0);
        chk("f1_busy", busy, 1);
        tick();
        mem_ack = 1'b1; mem_rdata = 20'h0002D;
        tick();
        mem_ack = 1'b0;
        chk("f1_ir_d", ir_d, 20'h0002D);
        chk("f1_pc", pc, 1);
        chk("f1_req_drop", mem_req, 0);
        chk("f1_no_w_yet", ir_w, 0);
        tick();
        chk("f1_ir_w", ir_w, 1);
        chk("f1_count", issue_count, 1);
        chk("f1_next_req", mem_req, 1);
        chk("f1_next_addr", mem_addr, 1);
        tick();
        chk("f1_w_pulse_end", ir_w, 0);

        // Stall held for three ISSUE cycles with word 0x00036.
        stall = 1'b1; mem_ack = 1'b1; mem_rdata = 20'h00036;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ir_w", ir_w, 0);
            chk("stall_ir_d", ir_d, 20'h00036);
        end
        stall = 1'b0;
        tick();
        chk("stall_release_w", ir_w, 1);
        chk("stall_count", issue_count, 2);
        chk("stall_ir_d_out", ir_d, 20'h00036);
        chk("stall_next_addr", mem_addr, 2);
        tick();
        chk("stall_single_pulse", ir_w, 0);

        // Advance to address 5, then redirect to 100 while that fetch is pending.
        fetch_issue(20'h00002);
        fetch_issue(20'h00003);
        fetch_issue(20'h00004);
        chk("pre_br_addr", mem_addr, 5);
        chk("pre_br_count", issue_count, 5);
        branch_valid = 1'b1; branch_target = 10'd100;
        tick();
        branch_valid = 1'b0;
        chk("br_pc", pc, 100);
        chk("br_addr_held", mem_addr, 5);
        chk("br_req_held", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 20'hBADBA;
        tick();
        mem_ack = 1'b0;
        chk("br_gap_req", mem_req, 0);
        chk("br_ir_d_kept", ir_d, 20'h00004);
        chk("br_no_w", ir_w, 0);
        chk("br_pc_noinc", pc, 100);
        tick();
        chk("br_refetch_req", mem_req, 1);
        chk("br_refetch_addr", mem_addr, 100);
        chk("br_gap_no_w", ir_w, 0);
        fetch_issue(20'h11111);
        chk("br_issue_d", ir_d, 20'h11111);
        chk("br_issue_w", ir_w, 1);
        chk("br_issue_count", issue_count, 6);
        chk("br_issue_pc", pc, 101);

        // Branch and ack in the same cycle, target 101.
        mem_ack = 1'b1; mem_rdata = 20'hEEEEE;
        branch_valid = 1'b1; branch_target = 10'd101;
        tick();
        mem_ack = 1'b0; branch_valid = 1'b0;
        chk("same_req_low", mem_req, 0);
        chk("same_pc", pc, 101);
        chk("same_no_w", ir_w, 0);
        chk("same_ir_d", ir_d, 20'h11111);
        tick();
        chk("same_req_high", mem_req, 1);
        chk("same_addr", mem_addr, 101);
        chk("same_count", issue_count, 6);

        // Redirect to 1023, then fetch and issue there so pc wraps to 0.
        branch_valid = 1'b1; branch_target = 10'd1023;
        tick();
        branch_valid = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("wrap_addr", mem_addr, 1023);
        fetch_issue(20'h3FF00);
        chk("wrap_pc", pc, 0);
        chk("wrap_addr0", mem_addr, 0);
        chk("wrap_count", issue_count, 7);

        // Redirect while a stalled instruction waits in ISSUE.
        stall = 1'b1; mem_ack = 1'b1; mem_rdata = 20'h55555;
        tick();
        mem_ack = 1'b0;
        branch_valid = 1'b1; branch_target = 10'd200;
        tick();
        branch_valid = 1'b0; stall = 1'b0;
        chk("iss_br_no_w", ir_w, 0);
        chk("iss_br_count", issue_count, 7);
        chk("iss_br_pc", pc, 200);
        chk("iss_br_gap", mem_req, 0);
        tick();
        chk("iss_br_addr", mem_addr, 200);
        chk("iss_br_no_w2", ir_w, 0);

        // run drops mid-fetch: the open request completes and issues, then idle.
        run = 1'b0;
        tick();
        chk("stop_req_held", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 20'h12345;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("stop_w", ir_w, 1);
        chk("stop_count", issue_count, 8);
        chk("stop_d", ir_d, 20'h12345);
        chk("stop_busy", busy, 0);
        chk("stop_req", mem_req, 0);
        tick();
        chk("stop_req_still", mem_req, 0);
        chk("stop_w_end", ir_w, 0);

        // Redirect while idle.
        branch_valid = 1'b1; branch_target = 10'd300;
        tick();
        branch_valid = 1'b0;
        chk("idle_br_pc", pc, 300);
        chk("idle_br_busy", busy, 0);
        chk("idle_br_req", mem_req, 0);

        // Asynchronous reset in the middle of a fetch, then a late ack.
        run = 1'b1;
        tick();
        chk("ar_req", mem_req, 1);
        chk("ar_addr", mem_addr, 300);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_mem_req", mem_req, 0);
        chk("ar_pc", pc, 0);
        chk("ar_ir_d", ir_d, 0);
        chk("ar_ir_w", ir_w, 0);
        chk("ar_count", issue_count, 0);
        chk("ar_busy", busy, 0);
        run = 1'b0;
        tick();
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 20'hABCDE;
        tick();
        mem_ack = 1'b0;
        chk("late_req", mem_req, 0);
        chk("late_ir_d", ir_d, 0);
        chk("late_ir_w", ir_w, 0);
        chk("late_busy", busy, 0);
        chk("late_pc", pc, 0);
        chk("late_count", issue_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
